multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle control unit for the MIPS core. It replaces the single-cycle decoder so that one shared ALU and one unified instruction/data memory can serve every instruction over several clock cycles. A Moore state machine reads the opcode and funct fields from the instruction register and drives every datapath enable and mux select each cycle. It also halts the core on an unsupported instruction and counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- op  in  6  instruction register bits [31:26]
- funct  in  6  instruction register bits [5:0]
- zero  in  1  ALU zero flag (current cycle)
- pc_en  out  1  PC register load enable
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write enable
- ir_write  out  1  instruction register load
- reg_write  out  1  register-file write enable
- reg_dst  out  1  A3 select: 0 = rt, 1 = rd
- mem_to_reg  out  1  WD3 select: 0 = ALUOut, 1 = memory data register
- jal_sel  out  1  forces A3 = 31 and WD3 = PC
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- alu_control  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 SLL, 101 SRL
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = sign-extended imm*4 (jump), 11 = register A (JR)
- halted  out  1  core stopped
- state_dbg  out  4  current state encoding
- retired  out  CNT_W  count of completed instructions

## Operation
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7
  - BRANCH=8, ADDIEX=9, ADDIWB=10, JAL=11, JR=12, HALT=13
  - Codes 14 and 15 are illegal and go to HALT.
- FETCH:
  - Asserts i_or_d=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_control=010, pc_src=00, pc_en=1.
  - Next state is DECODE.
- DECODE computes the branch target: alu_src_a=0, alu_src_b=11, alu_control=010. Next state by opcode:
  - 100011 (LW) or 101011 (SW) → MEMADR
  - 000000 with a supported funct → EXECUTE; funct 001000 → JR
  - 000100 or 000101 → BRANCH
  - 001000 → ADDIEX
  - 000011 → JAL
  - anything else → HALT
- MEMADR: alu_src_a=1, alu_src_b=10, ADD. Goes to MEMREAD for LW, MEMWRITE for SW.
- MEMREAD: i_or_d=1, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, then FETCH.
- MEMWRITE: i_or_d=1, mem_write=1, then FETCH.
- EXECUTE:
  - alu_src_a=1, alu_src_b=00, alu_control taken from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 000000 SLL, 000010 SRL.
  - Then ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, SUB, pc_src=01.
  - pc_en = zero for BEQ, ~zero for BNE.
  - Then FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, ADD, then ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, then FETCH.
- JAL:
  - reg_write=1, jal_sel=1. The PC register already holds PC+4, so it is the link value.
  - pc_src=10, pc_en=1, then FETCH.
- JR: alu_src_a=1, pc_src=11, pc_en=1, then FETCH.
- HALT:
  - halted=1, all enables 0.
  - Stays in HALT until reset.
- Outputs not listed for a state are 0.
- retired increments by 1 on every transition into FETCH from a state other than FETCH.
  - It wraps modulo 2^CNT_W.
  - It does not count entry into HALT.

## Timing
- Outputs are Moore: decoded combinationally from the state register only. The exceptions are pc_en in BRANCH (also depends on zero) and alu_control in EXECUTE (also depends on funct).
- Reset:
  - While reset=1, every enable (pc_en, ir_write, reg_write, mem_write) and every select is forced to 0.
  - On the reset edge: state=FETCH, retired=0, halted=0.
  - Reset mid-instruction abandons the instruction, and no write occurs in the reset cycle.
- Latency in cycles: LW 5; SW 4; R-type 4; ADDI 4; BEQ/BNE 3; JAL 3; JR 3.
- op and funct must be stable from the DECODE cycle until the instruction completes. The instruction register loads only in FETCH.

## Structure
- Package mips_pkg holds:
  - opcode and funct constants
  - the state encoding
  - the alu_control encodings
  - the alu_src_b and pc_src select encodings
- Sub-module mips_alu_dec maps funct to alu_control and flags an unsupported funct. It is used in DECODE and EXECUTE.

## Test plan
- Reset then LW (op 100011): states go 0,1,2,3,4,0; reg_write=1 only in MEMWB; retired=1 after 5 cycles.
- SW: mem_write=1 for exactly one cycle (MEMWRITE), i_or_d=1 in that cycle; 4 cycles total.
- BEQ with zero=1 gives pc_en=1 and pc_src=01 in BRANCH. BEQ with zero=0 gives pc_en=0. BNE gives the inverse.
- JAL: in state 11, jal_sel=1, reg_write=1, pc_src=10, pc_en=1; then FETCH.
- Illegal op 111111, or op 0 with funct 000001: reaches HALT (13) after DECODE, halted=1, enables stay 0 for 20+ cycles, retired unchanged.
- Reset asserted in MEMREAD: no reg_write in any cycle; state returns to 0; retired=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, functs,
// FSM state codes, ALU operations and datapath mux selects.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_JR  = 6'b001000;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_ADDIEX   = 4'd9,
      S_ADDIWB   = 4'd10,
      S_JAL      = 4'd11,
      S_JR       = 4'd12,
      S_HALT     = 4'd13
   } state_t;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;
   localparam logic [2:0] ALU_SLL = 3'b100;
   localparam logic [2:0] ALU_SRL = 3'b101;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_REGA   = 2'b11;

   // One bundle of every datapath control so a state can be decoded in one place.
   typedef struct packed {
      logic       pc_en;
      logic       i_or_d;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       jal_sel;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_control;
      logic [1:0] pc_src;
      logic       halted;
   } ctrl_t;

endpackage

// File: rtl/mips_alu_dec.sv
// R-type funct decoder: ALU operation plus a flag for functs the ALU cannot execute.
module mips_alu_dec
   import mips_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alu_control,
   output logic       supported
);

   always_comb begin
      alu_control = ALU_ADD;
      supported   = 1'b1;
      case (funct)
         FN_ADD:  alu_control = ALU_ADD;
         FN_SUB:  alu_control = ALU_SUB;
         FN_AND:  alu_control = ALU_AND;
         FN_OR:   alu_control = ALU_OR;
         FN_SLT:  alu_control = ALU_SLT;
         FN_SLL:  alu_control = ALU_SLL;
         FN_SRL:  alu_control = ALU_SRL;
         default: supported   = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath; halts on unsupported
// instructions and counts retired instructions.
module multicycle_ctrl
   import mips_pkg::*;
#(
   parameter int CNT_W = 32
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       op,
   input  logic [5:0]       funct,
   input  logic             zero,
   output logic             pc_en,
   output logic             i_or_d,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             jal_sel,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_control,
   output logic [1:0]       pc_src,
   output logic             halted,
   output logic [3:0]       state_dbg,
   output logic [CNT_W-1:0] retired
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic [2:0]       fn_alu_ctrl;
   logic             fn_supported;
   logic             retire;
   ctrl_t            ctrl;

   mips_alu_dec u_alu_dec (
      .funct       (funct),
      .alu_control (fn_alu_ctrl),
      .supported   (fn_supported)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d = S_HALT;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW:   state_d = S_MEMADR;
               OP_RTYPE: begin
                  if (funct == FN_JR)    state_d = S_JR;
                  else if (fn_supported) state_d = S_EXECUTE;
                  else                   state_d = S_HALT;
               end
               OP_BEQ, OP_BNE: state_d = S_BRANCH;
               OP_ADDI:        state_d = S_ADDIEX;
               OP_JAL:         state_d = S_JAL;
               default:        state_d = S_HALT;
            endcase
         end
         S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: state_d = S_FETCH;
         S_EXECUTE:  state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BRANCH:   state_d = S_FETCH;
         S_ADDIEX:   state_d = S_ADDIWB;
         S_ADDIWB:   state_d = S_FETCH;
         S_JAL:      state_d = S_FETCH;
         S_JR:       state_d = S_FETCH;
         S_HALT:     state_d = S_HALT;
         default:    state_d = S_HALT;
      endcase
   end

   // Every return to FETCH marks a completed instruction; HALT never returns.
   assign retire    = (state_d == S_FETCH) && (state_q != S_FETCH);
   assign retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};

   always_comb begin
      ctrl = '0;
      case (state_q)
         S_FETCH: begin
            ctrl.i_or_d      = 1'b0;
            ctrl.ir_write    = 1'b1;
            ctrl.alu_src_a   = 1'b0;
            ctrl.alu_src_b   = SRCB_FOUR;
            ctrl.alu_control = ALU_ADD;
            ctrl.pc_src      = PCSRC_ALU;
            ctrl.pc_en       = 1'b1;
         end
         S_DECODE: begin
            ctrl.alu_src_a   = 1'b0;
            ctrl.alu_src_b   = SRCB_IMM_SH2;
            ctrl.alu_control = ALU_ADD;
         end
         S_MEMADR: begin
            ctrl.alu_src_a   = 1'b1;
            ctrl.alu_src_b   = SRCB_IMM;
            ctrl.alu_control = ALU_ADD;
         end
         S_MEMREAD: ctrl.i_or_d = 1'b1;
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b0;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEMWRITE: begin
            ctrl.i_or_d    = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         S_EXECUTE: begin
            ctrl.alu_src_a   = 1'b1;
            ctrl.alu_src_b   = SRCB_REG;
            ctrl.alu_control = fn_alu_ctrl;
         end
         S_ALUWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b1;
            ctrl.mem_to_reg = 1'b0;
         end
         S_BRANCH: begin
            ctrl.alu_src_a   = 1'b1;
            ctrl.alu_src_b   = SRCB_REG;
            ctrl.alu_control = ALU_SUB;
            ctrl.pc_src      = PCSRC_ALUOUT;
            ctrl.pc_en       = (op == OP_BNE) ? ~zero : zero;
         end
         S_ADDIEX: begin
            ctrl.alu_src_a   = 1'b1;
            ctrl.alu_src_b   = SRCB_IMM;
            ctrl.alu_control = ALU_ADD;
         end
         S_ADDIWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b0;
            ctrl.mem_to_reg = 1'b0;
         end
         // The PC register already holds PC+4 here, so it is the link value.
         S_JAL: begin
            ctrl.reg_write = 1'b1;
            ctrl.jal_sel   = 1'b1;
            ctrl.pc_src    = PCSRC_JUMP;
            ctrl.pc_en     = 1'b1;
         end
         S_JR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.pc_src    = PCSRC_REGA;
            ctrl.pc_en     = 1'b1;
         end
         S_HALT:  ctrl.halted = 1'b1;
         default: ctrl = '0;
      endcase
      // Reset abandons any in-flight instruction without side effects.
      if (reset) begin
         ctrl = '0;
      end
   end

   assign pc_en       = ctrl.pc_en;
   assign i_or_d      = ctrl.i_or_d;
   assign mem_write   = ctrl.mem_write;
   assign ir_write    = ctrl.ir_write;
   assign reg_write   = ctrl.reg_write;
   assign reg_dst     = ctrl.reg_dst;
   assign mem_to_reg  = ctrl.mem_to_reg;
   assign jal_sel     = ctrl.jal_sel;
   assign alu_src_a   = ctrl.alu_src_a;
   assign alu_src_b   = ctrl.alu_src_b;
   assign alu_control = ctrl.alu_control;
   assign pc_src      = ctrl.pc_src;
   assign halted      = ctrl.halted;
   assign state_dbg   = state_q;
   assign retired     = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through
// its state sequence and checks controls, halting and the retire counter.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        reset, zero;
   logic [5:0]  op, funct;
   logic        pc_en, i_or_d, mem_write, ir_write, reg_write, reg_dst;
   logic        mem_to_reg, jal_sel, alu_src_a, halted;
   logic [1:0]  alu_src_b, pc_src;
   logic [2:0]  alu_control;
   logic [3:0]  state_dbg;
   logic [31:0] retired;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] exp_retired = 0;

   always #5 clk = ~clk;

   multicycle_ctrl #(.CNT_W(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .op          (op),
      .funct       (funct),
      .zero        (zero),
      .pc_en       (pc_en),
      .i_or_d      (i_or_d),
      .mem_write   (mem_write),
      .ir_write    (ir_write),
      .reg_write   (reg_write),
      .reg_dst     (reg_dst),
      .mem_to_reg  (mem_to_reg),
      .jal_sel     (jal_sel),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .alu_control (alu_control),
      .pc_src      (pc_src),
      .halted      (halted),
      .state_dbg   (state_dbg),
      .retired     (retired)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; op = 6'b100011; funct = 6'b0; zero = 1'b0;
      cyc(); cyc();
      vectors++;
      if ({pc_en, ir_write, reg_write, mem_write} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_enables got=%b want=0000", {pc_en, ir_write, reg_write, mem_write});
      end
      vectors++;
      if ({i_or_d, reg_dst, mem_to_reg, jal_sel, alu_src_a, alu_src_b, alu_control, pc_src, halted} !== 13'b0) begin
         miscompares++;
         $display("FAIL reset_selects got=%b want=0", {i_or_d, reg_dst, mem_to_reg, jal_sel, alu_src_a, alu_src_b, alu_control, pc_src, halted});
      end
      vectors++;
      if (state_dbg !== 4'd0 || retired !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_state got state=%0d retired=%0d want 0/0", state_dbg, retired);
      end
      reset = 1'b0;
      exp_retired = 0;
      #1;
      vectors++;
      if ({ir_write, pc_en, i_or_d, alu_src_a, alu_src_b, alu_control, pc_src} !== {1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 3'b010, 2'b00}) begin
         miscompares++;
         $display("FAIL fetch_controls got=%b want=11000101000", {ir_write, pc_en, i_or_d, alu_src_a, alu_src_b, alu_control, pc_src});
      end
   endtask

   task automatic test_lw();
      int exp_st[5] = '{0, 1, 2, 3, 4};
      op = 6'b100011; #1;
      for (int k = 0; k < 5; k++) begin
         vectors++;
         if (state_dbg !== 4'(exp_st[k]) || reg_write !== (k == 4)) begin
            miscompares++;
            $display("FAIL lw_step%0d got state=%0d reg_write=%b want state=%0d reg_write=%b", k, state_dbg, reg_write, exp_st[k], (k == 4));
         end
         if (k == 1) begin
            vectors++;
            if (alu_src_a !== 1'b0 || alu_src_b !== 2'b11 || alu_control !== 3'b010) begin
               miscompares++;
               $display("FAIL decode_ctrl got a=%b b=%b alu=%b want 0/11/010", alu_src_a, alu_src_b, alu_control);
            end
         end
         if (k == 3) begin
            vectors++;
            if (i_or_d !== 1'b1) begin
               miscompares++;
               $display("FAIL lw_memread_iord got=%b want=1", i_or_d);
            end
         end
         if (k == 4) begin
            vectors++;
            if (mem_to_reg !== 1'b1 || reg_dst !== 1'b0) begin
               miscompares++;
               $display("FAIL lw_memwb got m2r=%b dst=%b want 1/0", mem_to_reg, reg_dst);
            end
         end
         cyc();
      end
      exp_retired++;
      vectors++;
      if (state_dbg !== 4'd0 || retired !== exp_retired) begin
         miscompares++;
         $display("FAIL lw_retire got state=%0d retired=%0d want 0/%0d", state_dbg, retired, exp_retired);
      end
   endtask

   task automatic test_sw();
      int wr_cycles = 0;
      op = 6'b101011; #1;
      for (int k = 0; k < 4; k++) begin
         if (mem_write === 1'b1) wr_cycles++;
         if (k == 3) begin
            vectors++;
            if (state_dbg !== 4'd5 || mem_write !== 1'b1 || i_or_d !== 1'b1) begin
               miscompares++;
               $display("FAIL sw_memwrite got state=%0d mw=%b iord=%b want 5/1/1", state_dbg, mem_write, i_or_d);
            end
         end
         cyc();
      end
      exp_retired++;
      vectors++;
      if (wr_cycles != 1 || state_dbg !== 4'd0 || retired !== exp_retired) begin
         miscompares++;
         $display("FAIL sw_done got wr=%0d state=%0d retired=%0d want 1/0/%0d", wr_cycles, state_dbg, retired, exp_retired);
      end
   endtask

   task automatic test_rtype();
      logic [5:0] fns[7]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b000010};
      logic [2:0] ctls[7] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b100, 3'b101};
      for (int i = 0; i < 7; i++) begin
         op = 6'b000000; funct = fns[i];
         cyc(); cyc();
         vectors++;
         if (state_dbg !== 4'd6 || alu_control !== ctls[i] || alu_src_a !== 1'b1 || alu_src_b !== 2'b00) begin
            miscompares++;
            $display("FAIL rtype_exec funct=%b got state=%0d alu=%b a=%b b=%b want 6/%b/1/00", fns[i], state_dbg, alu_control, alu_src_a, alu_src_b, ctls[i]);
         end
         cyc();
         vectors++;
         if (state_dbg !== 4'd7 || reg_write !== 1'b1 || reg_dst !== 1'b1 || mem_to_reg !== 1'b0) begin
            miscompares++;
            $display("FAIL rtype_wb got state=%0d rw=%b dst=%b m2r=%b want 7/1/1/0", state_dbg, reg_write, reg_dst, mem_to_reg);
         end
         cyc();
         exp_retired++;
         vectors++;
         if (state_dbg !== 4'd0 || retired !== exp_retired) begin
            miscompares++;
            $display("FAIL rtype_retire got state=%0d retired=%0d want 0/%0d", state_dbg, retired, exp_retired);
         end
      end
   endtask

   task automatic test_branch();
      logic [5:0] ops[4]  = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
      logic       zs[4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic       pcen[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         op = ops[i]; zero = zs[i];
         cyc(); cyc();
         vectors++;
         if (state_dbg !== 4'd8 || pc_en !== pcen[i] || pc_src !== 2'b01 || alu_control !== 3'b110) begin
            miscompares++;
            $display("FAIL branch op=%b zero=%b got state=%0d pc_en=%b pc_src=%b alu=%b want 8/%b/01/110", ops[i], zs[i], state_dbg, pc_en, pc_src, alu_control, pcen[i]);
         end
         cyc();
         exp_retired++;
         vectors++;
         if (state_dbg !== 4'd0 || retired !== exp_retired) begin
            miscompares++;
            $display("FAIL branch_retire got state=%0d retired=%0d want 0/%0d", state_dbg, retired, exp_retired);
         end
      end
      zero = 1'b0;
   endtask

   task automatic test_jal();
      op = 6'b000011;
      cyc(); cyc();
      vectors++;
      if (state_dbg !== 4'd11 || {jal_sel, reg_write, pc_src, pc_en, mem_write} !== 6'b111010) begin
         miscompares++;
         $display("FAIL jal got state=%0d ctl=%b want 11/111010", state_dbg, {jal_sel, reg_write, pc_src, pc_en, mem_write});
      end
      cyc();
      exp_retired++;
      vectors++;
      if (state_dbg !== 4'd0 || retired !== exp_retired) begin
         miscompares++;
         $display("FAIL jal_retire got state=%0d retired=%0d want 0/%0d", state_dbg, retired, exp_retired);
      end
   endtask

   task automatic test_jr();
      op = 6'b000000; funct = 6'b001000;
      cyc(); cyc();
      vectors++;
      if (state_dbg !== 4'd12 || {alu_src_a, pc_src, pc_en, reg_write} !== 5'b11110) begin
         miscompares++;
         $display("FAIL jr got state=%0d ctl=%b want 12/11110", state_dbg, {alu_src_a, pc_src, pc_en, reg_write});
      end
      cyc();
      exp_retired++;
      vectors++;
      if (state_dbg !== 4'd0 || retired !== exp_retired) begin
         miscompares++;
         $display("FAIL jr_retire got state=%0d retired=%0d want 0/%0d", state_dbg, retired, exp_retired);
      end
   endtask

   task automatic test_addi();
      op = 6'b001000;
      cyc(); cyc();
      vectors++;
      if (state_dbg !== 4'd9 || {alu_src_a, alu_src_b, alu_control} !== 6'b110010) begin
         miscompares++;
         $display("FAIL addi_ex got state=%0d ctl=%b want 9/110010", state_dbg, {alu_src_a, alu_src_b, alu_control});
      end
      cyc();
      vectors++;
      if (state_dbg !== 4'd10 || {reg_write, reg_dst, mem_to_reg} !== 3'b100) begin
         miscompares++;
         $display("FAIL addi_wb got state=%0d ctl=%b want 10/100", state_dbg, {reg_write, reg_dst, mem_to_reg});
      end
      cyc();
      exp_retired++;
      vectors++;
      if (state_dbg !== 4'd0 || retired !== exp_retired) begin
         miscompares++;
         $display("FAIL addi_retire got state=%0d retired=%0d want 0/%0d", state_dbg, retired, exp_retired);
      end
   endtask

   task automatic test_reset_mid();
      op = 6'b100011;
      cyc(); cyc(); cyc();
      vectors++;
      if (state_dbg !== 4'd3) begin
         miscompares++;
         $display("FAIL midreset_reach got state=%0d want 3", state_dbg);
      end
      reset = 1'b1; #1;
      for (int k = 0; k < 2; k++) begin
         vectors++;
         if ({pc_en, ir_write, reg_write, mem_write, i_or_d} !== 5'b0) begin
            miscompares++;
            $display("FAIL midreset_ctl cyc%0d got=%b want 00000", k, {pc_en, ir_write, reg_write, mem_write, i_or_d});
         end
         cyc();
      end
      vectors++;
      if (state_dbg !== 4'd0 || retired !== 32'd0) begin
         miscompares++;
         $display("FAIL midreset_state got state=%0d retired=%0d want 0/0", state_dbg, retired);
      end
      reset = 1'b0;
      exp_retired = 0;
      #1;
      vectors++;
      if (reg_write !== 1'b0 || ir_write !== 1'b1) begin
         miscompares++;
         $display("FAIL midreset_fetch got rw=%b irw=%b want 0/1", reg_write, ir_write);
      end
   endtask

   task automatic test_illegal(input logic [5:0] bad_op, input logic [5:0] bad_fn);
      int bad = 0;
      op = bad_op; funct = bad_fn;
      cyc();
      vectors++;
      if (state_dbg !== 4'd1) begin
         miscompares++;
         $display("FAIL illegal_decode op=%b fn=%b got state=%0d want 1", bad_op, bad_fn, state_dbg);
      end
      cyc();
      for (int k = 0; k < 22; k++) begin
         if (state_dbg !== 4'd13 || halted !== 1'b1 || {pc_en, ir_write, reg_write, mem_write} !== 4'b0 || retired !== exp_retired) bad++;
         cyc();
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL illegal_halt op=%b fn=%b got %0d bad cycles (state=%0d halted=%b retired=%0d) want 0 (13/1/%0d)", bad_op, bad_fn, bad, state_dbg, halted, retired, exp_retired);
      end
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      exp_retired = 0;
      #1;
      vectors++;
      if (state_dbg !== 4'd0 || halted !== 1'b0 || retired !== 32'd0) begin
         miscompares++;
         $display("FAIL illegal_recover got state=%0d halted=%b retired=%0d want 0/0/0", state_dbg, halted, retired);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_lw();
      test_sw();
      test_rtype();
      test_branch();
      test_jal();
      test_jr();
      test_addi();
      test_reset_mid();
      test_lw();
      test_illegal(6'b111111, 6'b000000);
      test_illegal(6'b000000, 6'b000001);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
